dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 85 ++++++++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared funct3 codes, FSM state type and legality helper for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Unsigned load widths exist only for loads; stores accept B/H/W.
  function automatic logic type_legal(input logic we, input logic [2:0] mem_type);
    logic ok;
    case (mem_type)
      MEM_B, MEM_H, MEM_W: ok = 1'b1;
      MEM_BU, MEM_HU:      ok = ~we;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering, store replication and load extension for RV32I accesses.
// DMEM_MISALIGN_TRAP_EN enables the misalign flag; otherwise low address bits are ignored.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]      mem_type,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     raw_word,
  input  logic [31:0]     store_data,
  output logic [BE_W-1:0] byte_en,
  output logic [31:0]     store_word,
  output logic [31:0]     load_data,
  output logic            misalign
);

  logic [7:0]  byte_sel_s;
  logic [15:0] half_sel_s;

  // Lane selection, enables and extension; halfwords use addr_lo[1] only, words ignore addr_lo
  always_comb begin
    byte_sel_s = 8'd0;
    case (addr_lo)
      2'd0:    byte_sel_s = raw_word[7:0];
      2'd1:    byte_sel_s = raw_word[15:8];
      2'd2:    byte_sel_s = raw_word[23:16];
      2'd3:    byte_sel_s = raw_word[31:24];
      default: byte_sel_s = 8'd0;
    endcase
    if (addr_lo[1]) begin
      half_sel_s = raw_word[31:16];
    end else begin
      half_sel_s = raw_word[15:0];
    end

    byte_en    = 4'b0000;
    store_word = 32'd0;
    load_data  = 32'd0;
    case (mem_type)
      MEM_B: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
        load_data  = {{24{byte_sel_s[7]}}, byte_sel_s};
      end
      MEM_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
        load_data  = {24'd0, byte_sel_s};
      end
      MEM_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        load_data  = {{16{half_sel_s[15]}}, half_sel_s};
      end
      MEM_HU: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        load_data  = {16'd0, half_sel_s};
      end
      MEM_W: begin
        byte_en    = 4'b1111;
        store_word = store_data;
        load_data  = raw_word;
      end
      default: begin
        byte_en    = 4'b0000;
        store_word = 32'd0;
        load_data  = 32'd0;
      end
    endcase
  end

  // Misalignment detection, only meaningful when trapping is built in
  always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
    case (mem_type)
      MEM_H, MEM_HU: misalign = addr_lo[0];
      MEM_W:         misalign = (addr_lo != 2'd0);
      default:       misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable latency, RV32I lane access.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [2:0]  type_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] mem_r [DEPTH];

  logic            acc_we_s;
  logic [2:0]      acc_type_s;
  logic [31:0]     acc_addr_s;
  logic [31:0]     acc_wdata_s;
  logic [AW-1:0]   acc_idx_s;
  logic [31:0]     raw_s;
  logic [BE_W-1:0] byte_en_s;
  logic [31:0]     store_word_s;
  logic [31:0]     load_data_s;
  logic            misalign_s;
  logic            err_s;
  logic            commit_s;
  logic [31:0]     rdata_next_s;

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == RESP);

  // With zero wait cycles the commit happens on the acceptance edge, so use live inputs in IDLE
  always_comb begin
    if (state_r == IDLE) begin
      acc_we_s    = req_we;
      acc_type_s  = req_type;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_we_s    = we_r;
      acc_type_s  = type_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
    acc_idx_s = acc_addr_s[AW+1:2];
    raw_s     = mem_r[acc_idx_s];
  end

  dmem_lane_align u_align (
    .mem_type   (acc_type_s),
    .addr_lo    (acc_addr_s[1:0]),
    .raw_word   (raw_s),
    .store_data (acc_wdata_s),
    .byte_en    (byte_en_s),
    .store_word (store_word_s),
    .load_data  (load_data_s),
    .misalign   (misalign_s)
  );

  // Commit-edge detection, error classification and next response data
  always_comb begin
    if (state_r == IDLE) begin
      commit_s = req_valid && (WAIT_CYCLES == 0);
    end else if (state_r == WAIT) begin
      commit_s = (cnt_r == 4'd0);
    end else begin
      commit_s = 1'b0;
    end
    err_s = (acc_addr_s[31:2] >= 30'(DEPTH)) || !type_legal(acc_we_s, acc_type_s) || misalign_s;
    if (err_s || acc_we_s) begin
      rdata_next_s = 32'd0;
    end else begin
      rdata_next_s = load_data_s;
    end
  end

  // Storage is not reset; only an error-free store writes, and only its enabled lanes
  always_ff @(posedge clk) begin
    if (commit_s && acc_we_s && !err_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byte_en_s[i]) begin
          mem_r[acc_idx_s][8*i +: 8] <= store_word_s[8*i +: 8];
        end
      end
    end
  end

  // Request/response FSM with latched request and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      we_r       <= 1'b0;
      type_r     <= 3'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r    <= req_we;
            type_r  <= req_type;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state_r    <= RESP;
              resp_rdata <= rdata_next_s;
              resp_err   <= err_s;
            end else begin
              state_r <= WAIT;
              cnt_r   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r    <= RESP;
            resp_rdata <= rdata_next_s;
            resp_err   <= err_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_r    <= IDLE;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; follows DMEM_MISALIGN_TRAP_EN if defined.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH       = 1024;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; lat counts falling edges after the acceptance edge until resp_valid
  task automatic do_req(input logic we, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 50);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input string tag, input logic we, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(we, t, a, wd, rd, er, lat);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 32'(er), 32'(exp_err));
    check({tag, ".lat"}, 32'(lat), 32'(WAIT_CYCLES + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #12;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    access("sw10",  1'b1, MEM_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access("lw10a", 1'b0, MEM_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access("sb13",  1'b1, MEM_B,  32'h13, 32'h00000080, 32'h0, 1'b0);
    access("lb13",  1'b0, MEM_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    access("lbu13", 1'b0, MEM_BU, 32'h13, 32'h0, 32'h00000080, 1'b0);
    access("lw10b", 1'b0, MEM_W,  32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    access("sh12",  1'b1, MEM_H,  32'h12, 32'h00001234, 32'h0, 1'b0);
    access("lh12",  1'b0, MEM_H,  32'h12, 32'h0, 32'h00001234, 1'b0);
    access("lw10c", 1'b0, MEM_W,  32'h10, 32'h0, 32'h1234BEEF, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    access("lw11",  1'b0, MEM_W,  32'h11, 32'h0, 32'h0, 1'b1);
`else
    access("lw11",  1'b0, MEM_W,  32'h11, 32'h0, 32'h1234BEEF, 1'b0);
`endif
    access("lhu10", 1'b0, MEM_HU, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    access("lh10",  1'b0, MEM_H,  32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    access("lb10",  1'b0, MEM_B,  32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    access("lbu11", 1'b0, MEM_BU, 32'h11, 32'h0, 32'h000000BE, 1'b0);

    access("sw0",     1'b1, MEM_W, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    access("swlast",  1'b1, MEM_W, 32'(DEPTH*4-4), 32'hA5A5A5A5, 32'h0, 1'b0);
    access("lwlast",  1'b0, MEM_W, 32'(DEPTH*4-4), 32'h0, 32'hA5A5A5A5, 1'b0);
    access("lwoor",   1'b0, MEM_W, 32'(DEPTH*4), 32'h0, 32'h0, 1'b1);
    access("swoor",   1'b1, MEM_W, 32'(DEPTH*4), 32'h55555555, 32'h0, 1'b1);
    access("lw0",     1'b0, MEM_W, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
    access("ldbad",   1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    access("stbad",   1'b1, MEM_BU, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    access("lw10d",   1'b0, MEM_W, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_type = MEM_W; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 50);
    check("bp.seen", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.valid", 32'(resp_valid), 32'd1);
      check("bp.rdata", resp_rdata, 32'h1234BEEF);
      check("bp.req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.clr_valid", 32'(resp_valid), 32'd0);
    check("bp.clr_rdata", resp_rdata, 32'd0);

    access("sw20", 1'b1, MEM_W, 32'h20, 32'h11112222, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_type = MEM_W; req_addr = 32'h20; req_wdata = 32'h99999999;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rw.in_wait", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rw.ready", 32'(req_ready), 32'd1);
    check("rw.valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    access("rw.lw20", 1'b0, MEM_W, 32'h20, 32'h0, 32'h11112222, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
